// File: rtl/arb3_rr_pkg.sv
// Shared types and helpers for the three-way round-robin arbiter.
// The picker function is the single source of the rotate/priority rule.
package arb3_rr_pkg;

    localparam int NREQ = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Priority runs ptr+1, ptr+2, ptr+3 (mod 3); ptr=3 never occurs and falls to the ptr=2 order.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] req, input logic [1:0] ptr);
        logic [NREQ-1:0] win;
        win = '0;
        case (ptr)
            2'd0: begin
                if (req[1])      win = 3'b010;
                else if (req[2]) win = 3'b100;
                else if (req[0]) win = 3'b001;
            end
            2'd1: begin
                if (req[2])      win = 3'b100;
                else if (req[0]) win = 3'b001;
                else if (req[1]) win = 3'b010;
            end
            default: begin
                if (req[0])      win = 3'b001;
                else if (req[1]) win = 3'b010;
                else if (req[2]) win = 3'b100;
            end
        endcase
        return win;
    endfunction

    function automatic logic [1:0] onehot2id(input logic [NREQ-1:0] oh);
        logic [1:0] id;
        case (oh)
            3'b010:  id = 2'd1;
            3'b100:  id = 2'd2;
            default: id = 2'd0;
        endcase
        return id;
    endfunction

endpackage

// File: rtl/arb3_rr_if.sv
// Request/grant handshake between the three requesters and the arbiter.
interface arb3_rr_if import arb3_rr_pkg::*; ();

    logic [NREQ-1:0] req;
    logic            done;
    logic [NREQ-1:0] gnt;
    logic            gnt_vld;
    logic [1:0]      gnt_id;
    logic            any_req;

    modport master (
        output req, done,
        input  gnt, gnt_vld, gnt_id, any_req
    );

    modport slave (
        input  req, done,
        output gnt, gnt_vld, gnt_id, any_req
    );

endinterface

// File: rtl/arb3_rr_pick.sv
// Combinational rotate/priority picker; shared by the idle and release paths.
module arb3_rr_pick import arb3_rr_pkg::*; (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [NREQ-1:0] win
);

    assign win = rr_pick(req, ptr);

endmodule

// File: rtl/arb3_rr.sv
// Three-requester round-robin arbiter with done/drop release and an optional hold limit.
// Grant, valid and id are all registered from the same next-grant value.
module arb3_rr import arb3_rr_pkg::*; #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       ck,
    input  logic       nrst,
    arb3_rr_if.slave   bus
);

    localparam bit              HOLD_EN   = (HOLD_MAX > 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX > 0 ? HOLD_MAX - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;

    state_t          state, state_d;
    logic [1:0]      ptr, ptr_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [NREQ-1:0] gnt, gnt_d;
    logic [1:0]      gnt_id;
    logic            gnt_vld;

    logic [1:0]      pick_ptr;
    logic [NREQ-1:0] win;
    logic            any_req;
    logic            own_req;
    logic            other_req;
    logic            timeout;
    logic            rel;

    assign any_req   = |bus.req;
    assign own_req   = |(bus.req & gnt);
    assign other_req = |(bus.req & ~gnt);
    assign timeout   = HOLD_EN && (cnt == HOLD_LAST) && other_req;
    assign rel       = bus.done || !own_req || timeout;

    // While granted, arbitrate from the current owner so the release rotates past it.
    assign pick_ptr  = (state == GRANT) ? gnt_id : ptr;

    arb3_rr_pick u_pick (
        .req (bus.req),
        .ptr (pick_ptr),
        .win (win)
    );

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        cnt_d   = cnt;
        gnt_d   = gnt;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    gnt_d   = win;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (rel) begin
                    ptr_d   = gnt_id;
                    gnt_d   = win;
                    cnt_d   = '0;
                    state_d = any_req ? GRANT : IDLE;
                end else if (cnt != CNT_SAT) begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge ck) begin
        if (!nrst) begin
            state   <= IDLE;
            ptr     <= 2'd2;
            cnt     <= '0;
            gnt     <= '0;
            gnt_id  <= 2'd0;
            gnt_vld <= 1'b0;
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            cnt     <= cnt_d;
            gnt     <= gnt_d;
            gnt_id  <= onehot2id(gnt_d);
            gnt_vld <= |gnt_d;
        end
    end

    assign bus.gnt     = gnt;
    assign bus.gnt_vld = gnt_vld;
    assign bus.gnt_id  = gnt_id;
    assign bus.any_req = any_req;

    a_onehot: assert property (@(posedge ck) $onehot0(gnt));
    a_vld:    assert property (@(posedge ck) gnt_vld == (gnt != '0));

endmodule

// File: tb/tb_arb3_rr.sv
// Bench for arb3_rr: vector table plus rotation and hold-limit sequences, checked via a grant scoreboard.
module tb_arb3_rr;
    import arb3_rr_pkg::*;

    logic ck = 1'b0;
    logic nrst;

    arb3_rr_if bus ();

    arb3_rr #(.HOLD_MAX(3), .CNT_W(4)) dut (
        .ck   (ck),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic       rn;
        logic [2:0] req;
        logic       done;
        logic [2:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [2:0] sb[$];
    int         checks = 0;
    int         errors = 0;

    function automatic logic [1:0] ref_id(input logic [2:0] g);
        logic [1:0] id;
        id = 2'd0;
        if (g == 3'b010) id = 2'd1;
        if (g == 3'b100) id = 2'd2;
        return id;
    endfunction

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic rn, input logic [2:0] r, input logic d, input logic [2:0] e);
        vec_t v;
        v.rn = rn; v.req = r; v.done = d; v.exp = e;
        vecs.push_back(v);
    endtask

    // Drive one cycle of stimulus, queue the expected grant, compare after the edge.
    task automatic step(input logic rn, input logic [2:0] r, input logic d, input logic [2:0] e,
                        input string tag);
        logic [2:0] exp;
        @(negedge ck);
        nrst     = rn;
        bus.req  = r;
        bus.done = d;
        sb.push_back(e);
        #1;
        check3({tag, ".any_req"}, {2'b00, bus.any_req}, {2'b00, (r != 3'b000)});
        @(posedge ck);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.scoreboard: got empty queue, expected one entry", tag);
        end else begin
            exp = sb.pop_front();
            check3({tag, ".gnt"},     bus.gnt,                exp);
            check3({tag, ".gnt_vld"}, {2'b00, bus.gnt_vld},   {2'b00, (exp != 3'b000)});
            check3({tag, ".gnt_id"},  {1'b0, bus.gnt_id},     {1'b0, ref_id(exp)});
        end
    endtask

    initial begin
        logic [2:0] e;
        nrst     = 1'b0;
        bus.req  = 3'b000;
        bus.done = 1'b0;

        add(0, 3'b000, 0, 3'b000);  // reset
        add(1, 3'b001, 0, 3'b001);  // first grant, 1-cycle latency
        add(1, 3'b000, 0, 3'b000);  // owner drops -> idle
        add(0, 3'b111, 0, 3'b000);  // reset again, ptr back to 2
        add(1, 3'b111, 0, 3'b001);
        add(1, 3'b111, 1, 3'b010);  // done pulses rotate with no bubble
        add(1, 3'b111, 1, 3'b100);
        add(1, 3'b111, 1, 3'b001);
        add(1, 3'b111, 0, 3'b001);  // hold, cnt 0->1
        add(1, 3'b111, 0, 3'b001);  // cnt 1->2
        add(1, 3'b111, 0, 3'b010);  // hold limit hit with competitors
        add(1, 3'b001, 1, 3'b001);  // owner 1 releases, only 0 asks
        for (int i = 0; i < 5; i++)
            add(1, 3'b001, 0, 3'b001);  // lone owner keeps grant past the limit
        add(1, 3'b010, 0, 3'b010);  // owner 0 drops, 1 wins back-to-back
        add(1, 3'b000, 0, 3'b000);  // owner 1 drops, nothing pending
        add(1, 3'b000, 1, 3'b000);  // done while idle ignored
        add(1, 3'b010, 0, 3'b010);  // re-request granted after 1 cycle
        add(1, 3'b101, 1, 3'b100);  // done + owner drop: single rotation from 1
        add(1, 3'b111, 0, 3'b100);
        add(0, 3'b111, 0, 3'b000);  // reset mid-grant
        add(1, 3'b111, 0, 3'b001);  // ptr reset to 2 -> requester 0 first
        add(1, 3'b100, 0, 3'b100);
        add(1, 3'b011, 0, 3'b001);
        add(1, 3'b010, 0, 3'b010);

        foreach (vecs[i])
            step(vecs[i].rn, vecs[i].req, vecs[i].done, vecs[i].exp, $sformatf("vec%0d", i));

        // Continuous req=111 with done every cycle: strict 0,1,2 rotation.
        step(0, 3'b111, 0, 3'b000, "rot_rst");
        step(1, 3'b111, 0, 3'b001, "rot_first");
        e = 3'b001;
        for (int k = 0; k < 9; k++) begin
            e = {e[1:0], e[2]};
            step(1, 3'b111, 1, e, $sformatf("rot%0d", k));
        end

        // Two requesters, no done: hold limit alternates ownership every 3 cycles.
        e = 3'b001;
        for (int k = 1; k <= 12; k++) begin
            if (k % 3 == 0) e = (e == 3'b001) ? 3'b010 : 3'b001;
            step(1, 3'b011, 0, e, $sformatf("hold%0d", k));
        end

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
